// File: rtl/cook_timer_ctrl.sv
// Microwave cook timer: keypad entry of M..M:SS, 1 Hz BCD countdown, door interlock
// and a power-level duty cycle over a 10-second window.
module cook_timer_ctrl #(
    parameter int MIN_DIGITS  = 1,
    parameter int TICK_DIV    = 100,
    parameter int DONE_CYCLES = 300
) (
    input  logic                        clk,
    input  logic                        clear,
    input  logic                        key_valid,
    input  logic [3:0]                  key_code,
    input  logic                        start_btn,
    input  logic                        stop_btn,
    input  logic                        door_closed,
    input  logic [3:0]                  power_level,
    output logic [4*(MIN_DIGITS+2)-1:0] time_bcd,
    output logic                        magnetron,
    output logic                        done,
    output logic [2:0]                  state
);
    // state | meaning
    // IDLE  | time cleared, waiting for the first digit
    // ENTRY | digits shifting in, waiting for start
    // RUN   | counting down, magnetron gated by the duty cycle
    // PAUSE | time frozen after stop or door open
    // DONE  | cook finished, done held for DONE_CYCLES cycles

    localparam int ND = MIN_DIGITS + 2;
    localparam int TW = 4 * ND;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DONE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DONE_LOAD = DW'(DONE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_time;
    logic [PW-1:0]   r_presc;
    logic [3:0]      r_window;
    logic [3:0]      r_level;
    logic [DW-1:0]   r_done_cnt;

    logic            w_tick;
    logic            w_ev_start;
    logic            w_ev_tick;
    logic            w_ev_key;
    logic            w_leave_run;
    logic            w_pwm_on;
    logic [3:0]      w_level_in;
    logic [TW-1:0]   w_time_dec;

    // Tens of seconds borrow wraps to 5; every other digit is a plain decade.
    function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] t);
        logic [TW-1:0] res;
        logic          borrow;
        res    = t;
        borrow = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (borrow) begin
                if (t[4*i +: 4] == 4'd0) begin
                    res[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    res[4*i +: 4] = t[4*i +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // Highest asserted event wins: stop > door open > start > tick > key.
    assign w_leave_run = stop_btn || !door_closed;
    assign w_ev_start  = start_btn && !stop_btn && door_closed;
    assign w_tick      = (r_state == S_RUN) && (r_presc == PRESC_MAX);
    assign w_ev_tick   = w_tick && !w_leave_run && !start_btn;
    assign w_ev_key    = key_valid && (key_code <= 4'd9) && !w_leave_run && !start_btn;
    assign w_time_dec  = bcd_dec(r_time);
    assign w_level_in  = ((power_level == 4'd0) || (power_level > 4'd10)) ? 4'd10 : power_level;
    assign w_pwm_on    = (r_window < r_level);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state    <= S_IDLE;
            r_time     <= '0;
            r_presc    <= '0;
            r_window   <= 4'd0;
            r_level    <= 4'd10;
            r_done_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ev_key) begin
                        r_time  <= {{(TW-4){1'b0}}, key_code};
                        r_state <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (stop_btn) begin
                        r_time  <= '0;
                        r_state <= S_IDLE;
                    end else if (w_ev_start) begin
                        if (r_time != '0) begin
                            r_state  <= S_RUN;
                            r_presc  <= '0;
                            r_window <= 4'd0;
                            r_level  <= w_level_in;
                        end
                    end else if (w_ev_key) begin
                        r_time <= {r_time[TW-5:0], key_code};
                    end
                end
                S_RUN: begin
                    r_presc <= w_tick ? '0 : r_presc + PW'(1);
                    if (w_leave_run) begin
                        r_state <= S_PAUSE;
                    end else if (w_ev_tick) begin
                        r_time <= w_time_dec;
                        if (w_time_dec == '0) begin
                            r_state    <= S_DONE;
                            r_done_cnt <= DONE_LOAD;
                        end else begin
                            r_window <= (r_window == 4'd9) ? 4'd0 : r_window + 4'd1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (stop_btn) begin
                        r_time  <= '0;
                        r_state <= S_IDLE;
                    end else if (w_ev_start) begin
                        r_state  <= S_RUN;
                        r_presc  <= '0;
                        r_window <= 4'd0;
                        r_level  <= w_level_in;
                    end
                end
                S_DONE: begin
                    if (w_leave_run || (r_done_cnt == '0)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_done_cnt <= r_done_cnt - DW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_time  <= '0;
                end
            endcase
        end
    end

    // Door term is deliberately combinational so the interlock acts within the cycle.
    assign magnetron = (r_state == S_RUN) && w_pwm_on && door_closed;
    assign done      = (r_state == S_DONE);
    assign time_bcd  = r_time;
    assign state     = r_state;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Bench for cook_timer_ctrl: vector table, hand-written corner sequences and a
// randomized run against a decimal-arithmetic reference model.
module tb_cook_timer_ctrl;
    localparam int MD = 1;
    localparam int TD = 4;
    localparam int DC = 5;
    localparam int ND = MD + 2;
    localparam int TW = 4 * ND;
    localparam int POW = 1000;

    logic          clk = 1'b0;
    logic          clear;
    logic          key_valid;
    logic [3:0]    key_code;
    logic          start_btn;
    logic          stop_btn;
    logic          door_closed;
    logic [3:0]    power_level;
    logic [TW-1:0] time_bcd;
    logic          magnetron;
    logic          done;
    logic [2:0]    state;

    cook_timer_ctrl #(
        .MIN_DIGITS(MD), .TICK_DIV(TD), .DONE_CYCLES(DC)
    ) dut (
        .clk(clk), .clear(clear), .key_valid(key_valid), .key_code(key_code),
        .start_btn(start_btn), .stop_btn(stop_btn), .door_closed(door_closed),
        .power_level(power_level), .time_bcd(time_bcd), .magnetron(magnetron),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] to_bcd(input int num);
        logic [TW-1:0] r;
        int            v;
        v = num;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] pack_out(input logic [2:0] s, input logic [TW-1:0] t,
                                             input logic m, input logic d);
        return 32'({s, t, m, d});
    endfunction

    typedef struct {
        logic          kv;
        logic [3:0]    kc;
        logic          st;
        logic          sp;
        logic          dr;
        logic [2:0]    e_state;
        logic [TW-1:0] e_time;
        logic          e_mag;
        logic          e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic kv, input int kc, input logic st, input logic sp,
                                input logic dr, input int es, input int et, input logic em,
                                input logic ed);
        vec_t v;
        v.kv = kv; v.kc = 4'(kc); v.st = st; v.sp = sp; v.dr = dr;
        v.e_state = 3'(es); v.e_time = TW'(et); v.e_mag = em; v.e_done = ed;
        return v;
    endfunction

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input int k);
        key_valid = 1'b1; key_code = 4'(k);
        tick1();
        key_valid = 1'b0;
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        tick1();
        start_btn = 1'b0;
    endtask

    task automatic press_stop();
        stop_btn = 1'b1;
        tick1();
        stop_btn = 1'b0;
    endtask

    // Reference model: time kept as a decimal number MSS (minutes*100 + seconds).
    int m_state, m_num, m_run_cyc, m_secs, m_lvl, m_done_left;

    task automatic m_reset();
        m_state = 0; m_num = 0; m_run_cyc = 0; m_secs = 0; m_lvl = 10; m_done_left = 0;
    endtask

    task automatic m_enter_run(input logic [3:0] pl);
        m_state   = 2;
        m_run_cyc = 0;
        m_secs    = 0;
        m_lvl     = (pl == 0 || pl > 10) ? 10 : int'(pl);
    endtask

    task automatic m_step(input logic kv, input logic [3:0] kc, input logic st,
                          input logic sp, input logic dr, input logic [3:0] pl);
        bit key_ok;
        bit tick;
        int mins, secs;
        key_ok = kv && (kc <= 9);
        case (m_state)
            0: if (!sp && dr && !st && key_ok) begin m_num = int'(kc); m_state = 1; end
            1: begin
                if (sp) begin m_num = 0; m_state = 0; end
                else if (!dr) begin end
                else if (st) begin if (m_num != 0) m_enter_run(pl); end
                else if (key_ok) m_num = (m_num * 10 + int'(kc)) % POW;
            end
            2: begin
                tick = ((m_run_cyc % TD) == TD - 1);
                m_run_cyc++;
                if (sp || !dr) m_state = 3;
                else if (st) begin end
                else if (tick) begin
                    mins = m_num / 100;
                    secs = m_num % 100;
                    if (secs > 0) secs--;
                    else begin mins--; secs = 59; end
                    m_num = mins * 100 + secs;
                    if (m_num == 0) begin m_state = 4; m_done_left = DC; end
                    else m_secs++;
                end
            end
            3: begin
                if (sp) begin m_num = 0; m_state = 0; end
                else if (dr && st) m_enter_run(pl);
            end
            4: begin
                if (sp || !dr) m_state = 0;
                else begin
                    m_done_left--;
                    if (m_done_left == 0) m_state = 0;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    function automatic logic [31:0] m_expect(input logic dr);
        logic mag;
        mag = (m_state == 2) && ((m_secs % 10) < m_lvl) && dr;
        return pack_out(3'(m_state), to_bcd(m_num), mag, m_state == 4);
    endfunction

    initial begin
        int n;
        clear = 1'b1; key_valid = 1'b0; key_code = 4'd0; start_btn = 1'b0;
        stop_btn = 1'b0; door_closed = 1'b1; power_level = 4'd0;
        #2;
        chk("reset_state", pack_out(state, time_bcd, magnetron, done), 32'd0);
        tick1();
        clear = 1'b0;

        // keys 1,3,0 then start; first decrement TICK_DIV cycles after RUN entry
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 'h001, 0, 0));
        vecs.push_back(mk(1, 3, 0, 0, 1, 1, 'h013, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 'h130, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 2, 'h130, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 'h130, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 'h130, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 'h130, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 'h129, 1, 0));
        vecs.push_back(mk(1, 5, 0, 0, 1, 2, 'h129, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 'h129, 0, 0));
        vecs.push_back(mk(1, 7, 0, 0, 1, 3, 'h129, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 'h000, 0, 0));
        // four keys into three digits, then stop+start together
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 'h001, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 1, 1, 'h012, 0, 0));
        vecs.push_back(mk(1, 3, 0, 0, 1, 1, 'h123, 0, 0));
        vecs.push_back(mk(1, 4, 0, 0, 1, 1, 'h234, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 'h000, 0, 0));
        // invalid key, zero-time start, start with door open
        vecs.push_back(mk(1, 12, 0, 0, 1, 0, 'h000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 'h000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 'h000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 'h000, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 1, 1, 'h002, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 'h002, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 2, 'h002, 1, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 2, 'h002, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 'h001, 1, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 2, 'h001, 1, 0));
        for (int i = 0; i < DC; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 4, 'h000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'h000, 0, 0));

        foreach (vecs[i]) begin
            key_valid = vecs[i].kv; key_code = vecs[i].kc; start_btn = vecs[i].st;
            stop_btn = vecs[i].sp; door_closed = vecs[i].dr;
            tick1();
            key_valid = 1'b0; start_btn = 1'b0; stop_btn = 1'b0;
            #1;
            chk($sformatf("vec%0d", i), pack_out(state, time_bcd, magnetron, done),
                pack_out(vecs[i].e_state, vecs[i].e_time, vecs[i].e_mag, vecs[i].e_done));
        end
        door_closed = 1'b1;

        // door opens mid-count at 0:45; resume restarts the prescaler
        press_key(4); press_key(5); press_start();
        tick1(); tick1();
        chk("door_mag_before", 32'(magnetron), 32'd1);
        door_closed = 1'b0;
        #1;
        chk("door_mag_drop", 32'(magnetron), 32'd0);
        tick1();
        chk("door_pause", 32'({state, time_bcd}), 32'({3'd3, 12'h045}));
        tick1();
        chk("door_pause_hold", 32'({state, time_bcd}), 32'({3'd3, 12'h045}));
        door_closed = 1'b1;
        press_start();
        chk("resume_run", 32'({state, time_bcd, magnetron}), 32'({3'd2, 12'h045, 1'b1}));
        n = 0;
        do begin tick1(); n++; end while (time_bcd != 12'h044 && n < 10);
        chk("resume_first_dec", 32'(n), 32'd4);
        press_stop(); press_stop();
        chk("back_idle", 32'({state, time_bcd}), 32'd0);

        // power level 3 over a 10 s window: 12 cycles on, 28 off
        power_level = 4'd3;
        press_key(2); press_key(0); press_start();
        for (int c = 0; c < 80; c++) begin
            chk($sformatf("pwm_c%0d", c), 32'(magnetron), 32'((c % 40) < 12));
            tick1();
        end
        chk("pwm_expire", 32'({state, time_bcd, done}), 32'({3'd4, 12'h000, 1'b1}));
        repeat (DC - 1) tick1();
        chk("done_hold", 32'(state), 32'd4);
        tick1();
        chk("done_exit", 32'({state, done}), 32'd0);
        power_level = 4'd0;

        // asynchronous clear mid-run
        press_key(1); press_key(3); press_key(0); press_start();
        tick1(); tick1();
        chk("pre_clear", 32'({state, time_bcd}), 32'({3'd2, 12'h130}));
        #1 clear = 1'b1;
        #1;
        chk("clear_async", pack_out(state, time_bcd, magnetron, done), 32'd0);
        clear = 1'b0;
        press_key(7);
        chk("key_after_clear", 32'({state, time_bcd}), 32'({3'd1, 12'h007}));
        press_stop();

        // randomized run against the model
        clear = 1'b1; #1; clear = 1'b0;
        m_reset();
        door_closed = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int r;
            r = int'($urandom_range(0, 99));
            key_valid = 1'b0; start_btn = 1'b0; stop_btn = 1'b0;
            if ($urandom_range(0, 99) < 1) door_closed = ~door_closed;
            if (r < 30 && door_closed) begin
                key_valid = 1'b1;
                key_code = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'($urandom_range(0, 2));
            end else if (r < 40) begin
                start_btn = 1'b1;
            end else if (r < 41) begin
                stop_btn = 1'b1;
            end
            power_level = 4'($urandom_range(0, 15));
            #1;
            chk($sformatf("rand%0d", cyc), pack_out(state, time_bcd, magnetron, done),
                m_expect(door_closed));
            m_step(key_valid, key_code, start_btn, stop_btn, door_closed, power_level);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cook_timer_ctrl.md
# cook_timer_ctrl

Parametrised successor to the microwave timer and control path: one synchronous block that takes decoded keypad digits, accumulates an M…M:SS cook time, counts it down at 1 Hz, and drives the magnetron through a door interlock and a selectable power-level duty cycle. It has explicit RUN/PAUSE/DONE states and a timed done indication. It sits between the keypad scanner and debouncer upstream and the 7-segment decoder downstream, and replaces the separate timer, control-latch and clock-divider blocks.

## Interface
- MIN_DIGITS, 1: number of BCD minute digits (1–3); total digits ND = MIN_DIGITS+2.
- TICK_DIV, 100: clk cycles per one-second tick (≥2).
- DONE_CYCLES, 300: clk cycles the done indication is held (≥1).
- clk  in  1  system clock, rising-edge.
- clear  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle pulse: key_code holds a new digit.
- key_code  in  4  BCD digit 0–9; values 10–15 are ignored.
- start_btn  in  1  one-cycle pulse, already synchronised and debounced.
- stop_btn  in  1  one-cycle pulse, already synchronised and debounced.
- door_closed  in  1  level, 1 = door closed.
- power_level  in  4  1–10 seconds of magnetron on-time per 10 s window; 0 or >10 is treated as 10.
- time_bcd  out  4*ND  displayed time, BCD; the least significant nibble is units of seconds.
- magnetron  out  1  magnetron enable.
- done  out  1  high while in DONE.
- state  out  3  IDLE=0, ENTRY=1, RUN=2, PAUSE=3, DONE=4.

## Operation
- Command priority in any single cycle: stop_btn > door-open > start_btn > tick > key_valid. Every lower-priority event in that cycle is dropped.
- IDLE: time_bcd = 0. A valid key shifts the digit in at the units position and moves to ENTRY.
- ENTRY:
  - A valid key shifts time_bcd left one nibble and inserts the new digit; the most significant digit is lost.
  - stop_btn clears time to 0 and returns to IDLE.
  - start_btn with door_closed=1 and time≠0 goes to RUN; otherwise start_btn is ignored.
- RUN: on each tick the time is decremented in BCD.
  - Units of seconds: 0 wraps to 9 with a borrow.
  - Tens of seconds: on a borrow, 0 wraps to 5.
  - Minutes: plain BCD decade borrow.
  - Seconds values above 59 that were keyed in are not normalised; 1:99 counts 1:98, 1:97, and so on.
  - When time reaches 0, the next state is DONE.
  - stop_btn or door_closed=0 goes to PAUSE with time frozen.
- PAUSE:
  - start_btn with door_closed=1 resumes RUN.
  - stop_btn clears time and goes to IDLE.
  - Keys are ignored.
- DONE: done=1 and time_bcd=0. After DONE_CYCLES cycles, or earlier on stop_btn or door opening, the block goes to IDLE. Keys and start are ignored.
- Power:
  - power_level is sampled on every entry to RUN.
  - A window counter counts ticks modulo 10 and resets to 0 on every entry to RUN.
  - pwm_on is true while window < level.
- magnetron = (state==RUN) & pwm_on & door_closed. The AND with door_closed is combinational, so the magnetron drops in the same cycle the door opens.

## Timing
- Reset: state=IDLE, time_bcd=0, magnetron=0, done=0, prescaler=0, window=0, done counter=0.
- State, time, prescaler and window are registered. Each accepted event takes effect at the next rising edge.
- The prescaler counts 0..TICK_DIV-1 in RUN only, and resets to 0 on entry to RUN (both start and resume). A tick is asserted when the prescaler equals TICK_DIV-1.
- The first decrement occurs TICK_DIV cycles after the RUN entry edge.
- Magnetron timing: it rises in the first cycle state==RUN, and falls in the first cycle of PAUSE, DONE or IDLE.
- Expiry: the tick that makes time 0 also moves the state to DONE at the same edge, so time 0 is never displayed in RUN. done is high for exactly DONE_CYCLES cycles.
- A tick coinciding with stop_btn or door-open is lost, and no decrement happens.
- Asserting clear mid-operation returns all registers to their reset values immediately, independent of clk.

## Test plan
- MIN_DIGITS=1, TICK_DIV=4: keys 1,3,0, then start with door closed. Required: time_bcd=0x130 after the keys; magnetron=1 on the next cycle; 0x129 four cycles later.
- Running at 0x045: drop door_closed. Required: magnetron=0 in the same cycle, state=3, time held at 0x045. Then close the door and pulse start_btn: RUN resumes, and the next decrement to 0x044 comes 4 cycles after the resume edge.
- Keys 0,0,2, start, TICK_DIV=4, DONE_CYCLES=5. Required: sequence 0x002, 0x001, then DONE; done=1 for exactly 5 cycles; then IDLE with time 0.
- power_level=3, time 0x020, TICK_DIV=4. Required: magnetron high for 12 cycles, low for 28 cycles, repeating; door stays closed throughout.
- Keys 1,2,3,4 with MIN_DIGITS=1. Required: time_bcd=0x234. Then stop_btn and start_btn in the same cycle. Required: IDLE, time 0x000.
- clear pulsed mid-RUN at 0x130. Required: state=0, time_bcd=0, magnetron=0, done=0 asynchronously; the next key 7 gives 0x007.
